// File: rtl/sys_pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_pll_ctrl_pkg
// Shared definitions for the system PLL reset/lock sequencer: the state
// encoding (also exported on the debug `state` port), the default timing
// constants for a 50 MHz reference, and a small elaboration-time helper.
// -----------------------------------------------------------------------------
package sys_pll_ctrl_pkg;

    // Encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        WAIT_LOCK = 2'b01,
        LOCKED    = 2'b10,
        FAULT     = 2'b11
    } pll_state_e;

    // Defaults sized for the 50 MHz refclk.
    localparam int DEF_RST_CYCLES          = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;   // 10 ms
    localparam int DEF_MAX_RETRIES         = 3;

    // Larger of two integers, used when sizing the shared counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : sys_pll_ctrl_pkg

// File: rtl/sys_pll_lock_sync.sv
// -----------------------------------------------------------------------------
// sys_pll_lock_sync
// Two-flop synchronizer that brings the PLL `locked` flag, which is
// asynchronous to refclk, into the refclk domain.
//
// Ports:
//   clk       in   refclk
//   rst       in   asynchronous active-high reset; both flops clear to 0
//   async_in  in   raw asynchronous input
//   sync_out  out  synchronized copy, two refclk edges of latency
// -----------------------------------------------------------------------------
module sys_pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // meta_q may go metastable; only sync_q is allowed to fan out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule : sys_pll_lock_sync

// File: rtl/sys_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// sys_pll_lock_ctrl
// Reset/lock sequencer for the system PLL (50 MHz ref -> 1.536 MHz audio bit
// clock). Holds the PLL in reset for RST_CYCLES, waits for a stable lock for
// up to LOCK_TIMEOUT_CYCLES, retries up to MAX_RETRIES times, and raises a
// glitch-free pll_ready used to release downstream reset in the outclk_0
// consumers. Runs entirely in the refclk domain.
//
// Parameters (RST_CYCLES >= 2, LOCK_STABLE_CYCLES >= 1,
//             LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES, MAX_RETRIES >= 1):
//   RST_CYCLES           cycles pll_rst is held high per attempt
//   LOCK_STABLE_CYCLES   consecutive synchronized-lock cycles before ready
//   LOCK_TIMEOUT_CYCLES  cycles in WAIT_LOCK before an attempt fails
//   MAX_RETRIES          failed attempts tolerated before FAULT
//
// Ports:
//   refclk      in   50 MHz reference, the only clock
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL locked flag, asynchronous to refclk
//   relock_req  in   single-cycle request to restart the sequence
//   pll_rst     out  drives the PLL rst input
//   pll_ready   out  high while the PLL is qualified locked
//   fault       out  high in FAULT
//   retry_cnt   out  failed attempts since last lock or fault clear
//   state       out  current state encoding (debug)
// -----------------------------------------------------------------------------
module sys_pll_lock_ctrl
    import sys_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES          = DEF_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst,
    output logic                             pll_ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [1:0]                       state
);

    // The hold count and the timeout count never run at the same time, so
    // one counter serves both; it is sized for the larger terminal value.
    localparam int CNT_LAST_MAX = max2(RST_CYCLES, LOCK_TIMEOUT_CYCLES) - 1;
    localparam int CNT_W        = max2(1, $clog2(CNT_LAST_MAX + 1));
    localparam int STAB_W       = max2(1, $clog2(LOCK_STABLE_CYCLES));
    localparam int RETRY_W      = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST    = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic locked_s;

    pll_state_e         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [STAB_W-1:0]  stab_q,      stab_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic               pll_rst_q,   pll_rst_d;
    logic               pll_ready_q, pll_ready_d;
    logic               fault_q,     fault_d;

    logic               lock_done;
    logic               timed_out;

    sys_pll_lock_sync u_lock_sync (
        .clk      (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stab_d    = stab_q;
        retry_d   = retry_q;
        lock_done = 1'b0;
        timed_out = 1'b0;

        if (relock_req) begin
            // Restart takes priority over every other transition this cycle.
            state_d = HOLD;
            cnt_d   = '0;
            stab_d  = '0;
            if (state_q == FAULT) begin
                retry_d = '0;
            end
        end else begin
            unique case (state_q)
                HOLD: begin
                    stab_d = '0;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                WAIT_LOCK: begin
                    lock_done = locked_s && (stab_q == STAB_LAST);
                    timed_out = (cnt_q == TIMEOUT_LAST);
                    // A lock that completes on the timeout cycle still counts.
                    if (lock_done) begin
                        state_d = LOCKED;
                        retry_d = '0;
                        cnt_d   = '0;
                        stab_d  = '0;
                    end else if (timed_out) begin
                        cnt_d  = '0;
                        stab_d = '0;
                        if (retry_q >= RETRY_MAX) begin
                            state_d = FAULT;
                        end else begin
                            state_d = HOLD;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        // Any sampled low restarts the stability window.
                        stab_d = locked_s ? (stab_q + STAB_W'(1)) : '0;
                    end
                end

                LOCKED: begin
                    cnt_d  = '0;
                    stab_d = '0;
                    // Losing lock is not a failed attempt: retry_cnt untouched.
                    if (!locked_s) begin
                        state_d = HOLD;
                    end
                end

                FAULT: begin
                    cnt_d  = '0;
                    stab_d = '0;
                end

                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stab_d  = '0;
                end
            endcase
        end

        // Outputs come from the next state so they change on the same edge
        // as the state register and never glitch.
        pll_rst_d   = (state_d == HOLD) || (state_d == FAULT);
        pll_ready_d = (state_d == LOCKED);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            stab_q      <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            pll_ready_q <= pll_ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign pll_ready = pll_ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule : sys_pll_lock_ctrl
